// File: rtl/systolic_tile_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_tile_feeder_pkg : word types, feeder states and width helpers     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package systolic_tile_feeder_pkg;

   localparam int DEF_TILE      = 32;
   localparam int DEF_EXP_IN_A  = 3;
   localparam int DEF_FRAC_IN_A = 2;
   localparam int DEF_EXP_IN_B  = 3;
   localparam int DEF_FRAC_IN_B = 2;

   localparam int A_W = DEF_EXP_IN_A + DEF_FRAC_IN_A + 1;
   localparam int B_W = DEF_EXP_IN_B + DEF_FRAC_IN_B + 1;

   typedef logic [A_W-1:0] aWord_t;
   typedef logic [B_W-1:0] bWord_t;

   localparam int ROW_IDX_W = $clog2(DEF_TILE);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_SHIFT  = 2'd3
   } feeder_state_e;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_tile_feeder_skew.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skew_delay_line : DEPTH-stage delay that shifts only on advance            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module skew_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             adv_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic w_unused;
         assign w_unused = ^{clock, reset, adv_i};
         assign data_o   = data_i;
      end else begin : g_regs
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clock) begin
            if (reset) begin
               for (int s = 0; s < DEPTH; s++) begin
                  stage_q[s] <= '0;
               end
            end else if (adv_i) begin
               stage_q[0] <= data_i;
               for (int s = 1; s < DEPTH; s++) begin
                  stage_q[s] <= stage_q[s-1];
               end
            end
         end

         assign data_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_tile_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_tile_feeder : skews A/B k-steps into the grid and sequences       |
// |                        stream, drain and shift-out of the result rows      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module systolic_tile_feeder
   import systolic_tile_feeder_pkg::*;
#(
   parameter int TILE         = DEF_TILE,
   parameter int EXP_IN_A     = DEF_EXP_IN_A,
   parameter int FRAC_IN_A    = DEF_FRAC_IN_A,
   parameter int EXP_IN_B     = DEF_EXP_IN_B,
   parameter int FRAC_IN_B    = DEF_FRAC_IN_B,
   parameter int DRAIN_CYCLES = 2*TILE - 1
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [EXP_IN_A+FRAC_IN_A:0]           aColIn [TILE],
   input  logic [EXP_IN_B+FRAC_IN_B:0]           bRowIn [TILE],
   input  logic                                  inValid,
   input  logic                                  inLast,
   output logic                                  inReady,
   output logic [EXP_IN_A+FRAC_IN_A:0]           aNextIn [TILE],
   output logic [EXP_IN_B+FRAC_IN_B:0]           bNextIn [TILE],
   output logic                                  enableMul,
   output logic                                  enableShiftOut,
   output logic                                  outRowValid,
   output logic [idx_width(TILE)-1:0]            outRowIdx,
   output logic                                  tileDone,
   output logic                                  busy
);

   localparam int AW      = EXP_IN_A + FRAC_IN_A + 1;
   localparam int BW      = EXP_IN_B + FRAC_IN_B + 1;
   localparam int RIW     = idx_width(TILE);
   localparam int CNT_MAX = (DRAIN_CYCLES > TILE) ? DRAIN_CYCLES : TILE;
   localparam int CNT_W   = idx_width(CNT_MAX);

   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(TILE - 1);

   feeder_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tile_done_q, tile_done_d;
   logic             row_valid_q;
   logic [RIW-1:0]   row_idx_q;
   logic             accept;
   logic             advance;

   assign inReady   = (state_q == ST_IDLE) || (state_q == ST_STREAM);
   assign accept    = inValid && inReady;
   assign advance   = accept || (state_q == ST_DRAIN);
   assign enableMul = advance;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      tile_done_d    = 1'b0;
      enableShiftOut = 1'b0;
      case (state_q)
         ST_IDLE, ST_STREAM: begin
            if (accept) begin
               if (inLast) begin
                  state_d = ST_DRAIN;
                  cnt_d   = DRAIN_LOAD;
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = ST_SHIFT;
               cnt_d   = SHIFT_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SHIFT: begin
            enableShiftOut = 1'b1;
            if (cnt_q == '0) begin
               state_d     = ST_IDLE;
               tile_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The grid registers cOut, so the row becomes visible one cycle after its shift.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tile_done_q <= 1'b0;
         row_valid_q <= 1'b0;
         row_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tile_done_q <= tile_done_d;
         row_valid_q <= enableShiftOut;
         if (enableShiftOut) begin
            row_idx_q <= cnt_q[RIW-1:0];
         end
      end
   end

   assign outRowValid = row_valid_q;
   assign outRowIdx   = row_idx_q;
   assign tileDone    = tile_done_q;
   assign busy        = (state_q != ST_IDLE);

   generate
      for (genvar gi = 0; gi < TILE; gi++) begin : g_lane
         logic [AW-1:0] a_in;
         logic [BW-1:0] b_in;

         // DRAIN pushes zeros behind the last beat; a stall pushes nothing.
         assign a_in = accept ? aColIn[gi] : '0;
         assign b_in = accept ? bRowIn[gi] : '0;

         skew_delay_line #(
            .WIDTH (AW),
            .DEPTH (gi)
         ) u_skew_a (
            .clock  (clock),
            .reset  (reset),
            .adv_i  (advance),
            .data_i (a_in),
            .data_o (aNextIn[gi])
         );

         skew_delay_line #(
            .WIDTH (BW),
            .DEPTH (gi)
         ) u_skew_b (
            .clock  (clock),
            .reset  (reset),
            .adv_i  (advance),
            .data_i (b_in),
            .data_o (bNextIn[gi])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_systolic_tile_feeder : directed vectors plus a grid/collector model     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_systolic_tile_feeder;

   localparam int T = 4;
   localparam int W = 6;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] aColIn [T];
   logic [W-1:0] bRowIn [T];
   logic         inValid = 1'b0;
   logic         inLast  = 1'b0;
   logic         inReady;
   logic [W-1:0] aNextIn [T];
   logic [W-1:0] bNextIn [T];
   logic         enableMul, enableShiftOut, outRowValid, tileDone, busy;
   logic [1:0]   outRowIdx;

   int compared = 0;
   int failed   = 0;

   always #5 clock = ~clock;

   systolic_tile_feeder #(
      .TILE (T), .EXP_IN_A (3), .FRAC_IN_A (2), .EXP_IN_B (3), .FRAC_IN_B (2),
      .DRAIN_CYCLES (2*T - 1)
   ) dut (
      .clock (clock), .reset (reset), .aColIn (aColIn), .bRowIn (bRowIn),
      .inValid (inValid), .inLast (inLast), .inReady (inReady),
      .aNextIn (aNextIn), .bNextIn (bNextIn), .enableMul (enableMul),
      .enableShiftOut (enableShiftOut), .outRowValid (outRowValid),
      .outRowIdx (outRowIdx), .tileDone (tileDone), .busy (busy)
   );

   // ---------------- grid and collector model ----------------
   logic [31:0] acc [T][T];
   logic [W-1:0] ar [T][T];
   logic [W-1:0] br [T][T];
   logic [31:0] cOut [T];
   int          C [T][T];
   int          rows_seen;

   always @(posedge clock) begin : grid_model
      logic [W-1:0] a_in, b_in;
      if (reset) begin
         for (int i = 0; i < T; i++) begin
            cOut[i] <= '0;
            for (int j = 0; j < T; j++) begin
               acc[i][j] <= '0; ar[i][j] <= '0; br[i][j] <= '0;
            end
         end
      end else begin
         if (enableMul) begin
            for (int i = 0; i < T; i++) begin
               for (int j = 0; j < T; j++) begin
                  if (j == 0) a_in = aNextIn[i]; else a_in = ar[i][j-1];
                  if (i == 0) b_in = bNextIn[j]; else b_in = br[i-1][j];
                  acc[i][j] <= acc[i][j] + 32'(a_in) * 32'(b_in);
                  ar[i][j]  <= a_in;
                  br[i][j]  <= b_in;
               end
            end
         end
         if (enableShiftOut) begin
            for (int j = 0; j < T; j++) begin
               cOut[j] <= acc[T-1][j];
               for (int i = 0; i < T; i++) begin
                  if (i == 0) acc[i][j] <= '0; else acc[i][j] <= acc[i-1][j];
               end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && outRowValid) begin
         for (int j = 0; j < T; j++) C[outRowIdx][j] = int'(cOut[j]);
         rows_seen = rows_seen + 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] want);
      compared++;
      if (got !== want) begin
         failed++;
         $display("FAIL %s[%0d]: got %0h required %0h", nm, idx, got, want);
      end
   endtask

   function automatic logic [3:0][W-1:0] L(input int l0, input int l1, input int l2, input int l3);
      return {W'(l3), W'(l2), W'(l1), W'(l0)};
   endfunction

   function automatic logic [3:0][W-1:0] packA();
      return {aNextIn[3], aNextIn[2], aNextIn[1], aNextIn[0]};
   endfunction

   function automatic logic [3:0][W-1:0] packB();
      return {bNextIn[3], bNextIn[2], bNextIn[1], bNextIn[0]};
   endfunction

   typedef struct packed {
      logic            vin;
      logic            vlast;
      logic [3:0][W-1:0] a;
      logic [3:0][W-1:0] b;
      logic            en;
      logic            sh;
      logic            rv;
      logic [1:0]      ridx;
      logic            td;
      logic            rdy;
      logic            bsy;
      logic [3:0][W-1:0] an;
      logic [3:0][W-1:0] bn;
   } vec_t;

   function automatic vec_t mk(input logic vin, input logic vlast,
                               input logic [3:0][W-1:0] a, input logic [3:0][W-1:0] b,
                               input logic en, input logic sh, input logic rv, input logic [1:0] ridx,
                               input logic td, input logic rdy, input logic bsy,
                               input logic [3:0][W-1:0] an, input logic [3:0][W-1:0] bn);
      vec_t v;
      v.vin = vin; v.vlast = vlast; v.a = a; v.b = b;
      v.en = en; v.sh = sh; v.rv = rv; v.ridx = ridx;
      v.td = td; v.rdy = rdy; v.bsy = bsy; v.an = an; v.bn = bn;
      return v;
   endfunction

   int tA [T][T];
   int tB [T][T];

   task automatic clear_c();
      for (int i = 0; i < T; i++) for (int j = 0; j < T; j++) C[i][j] = -1;
      rows_seen = 0;
   endtask

   // Entered mid-cycle with the DUT ready; returns at the negedge after the last beat.
   task automatic send_tile(input string nm, input bit gaps);
      for (int k = 0; k < T; k++) begin
         if (gaps && k > 0) begin
            inValid = 1'b0;
            #1 chk({nm, "_gap_mul"}, k, enableMul, 1'b0);
            @(negedge clock);
         end
         for (int i = 0; i < T; i++) begin
            aColIn[i] = W'(tA[i][k]);
            bRowIn[i] = W'(tB[k][i]);
         end
         inValid = 1'b1;
         inLast  = (k == T-1);
         #1;
         chk({nm, "_beat_ready"}, k, inReady, 1'b1);
         chk({nm, "_beat_mul"}, k, enableMul, 1'b1);
         @(negedge clock);
      end
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit ok = 1'b0;
      #1;
      for (int n = 0; n < 200 && !ok; n++) begin
         if (tileDone) ok = 1'b1;
         else begin
            @(negedge clock);
            #1;
         end
      end
      chk({nm, "_tile_done_seen"}, 0, ok, 1'b1);
   endtask

   task automatic check_result(input string nm);
      for (int i = 0; i < T; i++) begin
         for (int j = 0; j < T; j++) begin
            int e = 0;
            for (int k = 0; k < T; k++) e += tA[i][k] * tB[k][j];
            chk({nm, "_c"}, i*T + j, 64'(C[i][j]), 64'(e));
         end
      end
      chk({nm, "_rows"}, 0, 64'(rows_seen), 64'(T));
   endtask

   task automatic load_ident_diag();
      for (int i = 0; i < T; i++) for (int j = 0; j < T; j++) begin
         tA[i][j] = (i == j) ? 1 : 0;
         tB[i][j] = (i == j) ? 5 + i : 0;
      end
   endtask

   int MA1 [T][T] = '{'{1, 2, 0, 1}, '{0, 1, 3, 2}, '{2, 0, 1, 1}, '{1, 1, 1, 0}};
   int MB1 [T][T] = '{'{1, 0, 2, 1}, '{3, 1, 0, 0}, '{0, 2, 1, 1}, '{1, 1, 0, 2}};
   int MA2 [T][T] = '{'{3, 0, 1, 2}, '{1, 4, 0, 0}, '{0, 2, 2, 1}, '{5, 1, 0, 3}};
   int MB2 [T][T] = '{'{2, 1, 0, 0}, '{0, 3, 1, 2}, '{1, 0, 4, 1}, '{0, 2, 1, 1}};

   vec_t vecs [14];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][W-1:0] Z, G;
      Z = L(0, 0, 0, 0);
      G = L(9, 9, 9, 9);
      //                vin vl a            b            en sh rv ix td rdy bsy an            bn
      vecs[0]  = mk(1, 1, L(1,2,3,4), L(5,6,7,8), 1, 0, 0, 0, 0, 1, 0, L(1,0,0,0), L(5,0,0,0));
      vecs[1]  = mk(1, 1, G, G,                   1, 0, 0, 0, 0, 0, 1, L(0,2,0,0), L(0,6,0,0));
      vecs[2]  = mk(1, 1, G, G,                   1, 0, 0, 0, 0, 0, 1, L(0,0,3,0), L(0,0,7,0));
      vecs[3]  = mk(1, 1, G, G,                   1, 0, 0, 0, 0, 0, 1, L(0,0,0,4), L(0,0,0,8));
      vecs[4]  = mk(1, 1, G, G,                   1, 0, 0, 0, 0, 0, 1, Z, Z);
      vecs[5]  = mk(1, 1, G, G,                   1, 0, 0, 0, 0, 0, 1, Z, Z);
      vecs[6]  = mk(1, 1, G, G,                   1, 0, 0, 0, 0, 0, 1, Z, Z);
      vecs[7]  = mk(1, 1, G, G,                   1, 0, 0, 0, 0, 0, 1, Z, Z);
      vecs[8]  = mk(1, 1, G, G,                   0, 1, 0, 0, 0, 0, 1, Z, Z);
      vecs[9]  = mk(1, 1, G, G,                   0, 1, 1, 3, 0, 0, 1, Z, Z);
      vecs[10] = mk(1, 1, G, G,                   0, 1, 1, 2, 0, 0, 1, Z, Z);
      vecs[11] = mk(1, 1, G, G,                   0, 1, 1, 1, 0, 0, 1, Z, Z);
      vecs[12] = mk(0, 0, Z, Z,                   0, 0, 1, 0, 1, 1, 0, Z, Z);
      vecs[13] = mk(0, 0, Z, Z,                   0, 0, 0, 0, 0, 1, 0, Z, Z);

      for (int i = 0; i < T; i++) begin
         aColIn[i] = '0;
         bRowIn[i] = '0;
      end
      clear_c();

      // Reset state
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_mul", 0, enableMul, 1'b0);
      chk("rst_shift", 0, enableShiftOut, 1'b0);
      chk("rst_ready", 0, inReady, 1'b1);
      chk("rst_busy", 0, busy, 1'b0);
      chk("rst_rowvalid", 0, outRowValid, 1'b0);
      chk("rst_rowidx", 0, 64'(outRowIdx), 64'(0));
      chk("rst_done", 0, tileDone, 1'b0);
      chk("rst_anext", 0, packA(), '0);
      chk("rst_bnext", 0, packB(), '0);

      // Single-beat tile, inputs held valid through DRAIN/SHIFT with junk
      for (int v = 0; v < 14; v++) begin
         @(negedge clock);
         inValid = vecs[v].vin;
         inLast  = vecs[v].vlast;
         for (int i = 0; i < T; i++) begin
            aColIn[i] = vecs[v].a[i];
            bRowIn[i] = vecs[v].b[i];
         end
         #1;
         chk("vec_mul", v, enableMul, vecs[v].en);
         chk("vec_shift", v, enableShiftOut, vecs[v].sh);
         chk("vec_rowvalid", v, outRowValid, vecs[v].rv);
         chk("vec_rowidx", v, 64'(outRowIdx), 64'(vecs[v].ridx));
         chk("vec_done", v, tileDone, vecs[v].td);
         chk("vec_ready", v, inReady, vecs[v].rdy);
         chk("vec_busy", v, busy, vecs[v].bsy);
         chk("vec_anext", v, packA(), vecs[v].an);
         chk("vec_bnext", v, packB(), vecs[v].bn);
      end
      inValid = 1'b0;
      inLast  = 1'b0;

      // K=4 identity x diag, back-to-back beats
      load_ident_diag();
      clear_c();
      @(negedge clock);
      send_tile("b2b", 1'b0);
      wait_done("b2b");
      check_result("b2b");
      @(negedge clock);
      #1 chk("b2b_busy_after_done", 0, busy, 1'b0);

      // Same tile with bubbles between beats
      clear_c();
      send_tile("gap", 1'b1);
      wait_done("gap");
      check_result("gap");

      // Reset during the second DRAIN cycle
      clear_c();
      @(negedge clock);
      send_tile("rstmid", 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rstmid_anext", 0, packA(), '0);
      chk("rstmid_bnext", 0, packB(), '0);
      chk("rstmid_mul", 0, enableMul, 1'b0);
      chk("rstmid_ready", 0, inReady, 1'b1);
      chk("rstmid_busy", 0, busy, 1'b0);
      tA = MA1;
      tB = MB1;
      clear_c();
      send_tile("fresh", 1'b0);
      wait_done("fresh");
      check_result("fresh");

      // Two tiles back-to-back: second starts in the tileDone cycle
      @(negedge clock);
      load_ident_diag();
      clear_c();
      send_tile("pair1", 1'b0);
      wait_done("pair1");
      check_result("pair1");
      tA = MA2;
      tB = MB2;
      clear_c();
      send_tile("pair2", 1'b0);
      wait_done("pair2");
      check_result("pair2");

      repeat (2) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
`default_nettype wire
